cordic_gain_comp: RTL and testbench

//  Downstream stage of the unrolled CORDIC rotator. Removes the CORDIC gain from the

---
 rtl/cordic_pkg.sv | 8 +
 rtl/cordic_gain_comp_if.sv | 13 +
 rtl/cordic_gain_lane.sv | 37 +++
 rtl/cordic_gain_comp.sv | 43 ++++
 tb/tb_cordic_gain_comp.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and FSM state type for the CORDIC gain compensation stage.
package cordic_pkg;
  localparam int CORDIC_DATA_W = 11;
  localparam int CORDIC_FRAC_W = 8;
  localparam int CORDIC_GAIN_Q8 = 155;
  localparam int CORDIC_ACC_W = CORDIC_DATA_W + CORDIC_FRAC_W;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
endpackage

// File: rtl/cordic_gain_comp_if.sv
// cordic_gain_comp_if: input/output valid-ready bundle; master drives vectors, slave is the compensator.
interface cordic_gain_comp_if #(parameter int DATA_W = cordic_pkg::CORDIC_DATA_W);
  logic in_valid;
  logic in_ready;
  logic signed [DATA_W-1:0] Vx;
  logic signed [DATA_W-1:0] Vy;
  logic out_valid;
  logic out_ready;
  logic signed [DATA_W-1:0] C_Vx;
  logic signed [DATA_W-1:0] C_Vy;
  modport master (output in_valid, Vx, Vy, out_ready, input in_ready, out_valid, C_Vx, C_Vy);
  modport slave (input in_valid, Vx, Vy, out_ready, output in_ready, out_valid, C_Vx, C_Vy);
endinterface

// File: rtl/cordic_gain_lane.sv
// cordic_gain_lane: one operand register and shift-add accumulator; final scale-down by FRAC_W.
// CORDIC_GAIN_ROUND_EN selects round-half-up instead of floor on the final shift.
module cordic_gain_lane #(
  parameter int DATA_W = cordic_pkg::CORDIC_DATA_W,
  parameter int FRAC_W = cordic_pkg::CORDIC_FRAC_W,
  parameter int ACC_W = DATA_W + FRAC_W,
  parameter int CNT_W = $clog2(FRAC_W)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic add_en,
  input  logic [CNT_W-1:0] shift,
  input  logic signed [DATA_W-1:0] v,
  output logic signed [DATA_W-1:0] c
);
  logic signed [DATA_W-1:0] opr;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] rnd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opr <= '0;
      acc <= '0;
    end else if (load) begin
      opr <= v;
      acc <= '0;
    end else if (add_en) begin
      acc <= acc + (ACC_W'(opr) <<< shift);
    end
  end
`ifdef CORDIC_GAIN_ROUND_EN
  assign rnd = acc + ACC_W'(1 << (FRAC_W - 1));
`else
  assign rnd = acc;
`endif
  assign c = rnd[FRAC_W +: DATA_W];
endmodule

// File: rtl/cordic_gain_comp.sv
// cordic_gain_comp: multiplies a CORDIC vector by GAIN/2**FRAC_W, one constant bit per cycle.
// Optional build macro CORDIC_GAIN_ROUND_EN rounds half up instead of truncating.
module cordic_gain_comp
  import cordic_pkg::*;
#(
  parameter int DATA_W = CORDIC_DATA_W,
  parameter int FRAC_W = CORDIC_FRAC_W,
  parameter int GAIN = CORDIC_GAIN_Q8
) (
  input logic clk,
  input logic rst_n,
  cordic_gain_comp_if.slave bus
);
  localparam int CNT_W = $clog2(FRAC_W);
  localparam logic [FRAC_W-1:0] GAIN_B = GAIN[FRAC_W-1:0];
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic load, add_en;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= state == MUL ? cnt + 1'b1 : '0;
    end
  end
  always_comb begin
    nxt = state == IDLE ? (bus.in_valid ? MUL : IDLE) :
          state == MUL  ? (cnt == CNT_W'(FRAC_W - 1) ? DONE : MUL) :
                          (bus.out_ready ? IDLE : DONE);
    load = state == IDLE && bus.in_valid;
    add_en = state == MUL && GAIN_B[cnt];
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  cordic_gain_lane #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .CNT_W(CNT_W)) u_x (
    .clk(clk), .rst_n(rst_n), .load(load), .add_en(add_en), .shift(cnt), .v(bus.Vx), .c(bus.C_Vx)
  );
  cordic_gain_lane #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .CNT_W(CNT_W)) u_y (
    .clk(clk), .rst_n(rst_n), .load(load), .add_en(add_en), .shift(cnt), .v(bus.Vy), .c(bus.C_Vy)
  );
endmodule

// File: tb/tb_cordic_gain_comp.sv
// tb_cordic_gain_comp: directed vector table plus handshake, back-pressure and reset sequences.
module tb_cordic_gain_comp;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int errors = 0;
  cordic_gain_comp_if bus ();
  cordic_gain_comp dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {int x; int y; int ex; int ey;} vec_t;
  vec_t tv[8];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!bus.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 0, 1);
  endtask

  // Presents a vector at a negedge; lat counts posedges from the accept edge (as 1) to out_valid.
  task automatic send(input int x, input int y, output int lat);
    wait_ready();
    bus.Vx = 11'(x);
    bus.Vy = 11'(y);
    bus.in_valid = 1;
    @(posedge clk);
    lat = 1;
    #1 bus.in_valid = 0;
    @(negedge clk);
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic drain();
    bus.out_ready = 1;
    @(posedge clk);
    #1 bus.out_ready = 0;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    bus.in_valid = 0;
    bus.out_ready = 0;
    bus.Vx = '0;
    bus.Vy = '0;
`ifdef CORDIC_GAIN_ROUND_EN
    tv[0] = '{256, 0, 155, 0};
    tv[1] = '{-256, 1023, -155, 619};
    tv[2] = '{-1023, 1, -619, 1};
    tv[3] = '{-1024, -1024, -620, -620};
    tv[4] = '{1023, -1, 619, -1};
    tv[5] = '{100, -100, 61, -61};
    tv[6] = '{1, -2, 1, -1};
    tv[7] = '{0, 0, 0, 0};
`else
    tv[0] = '{256, 0, 155, 0};
    tv[1] = '{-256, 1023, -155, 619};
    tv[2] = '{-1023, 1, -620, 0};
    tv[3] = '{-1024, -1024, -620, -620};
    tv[4] = '{1023, -1, 619, -1};
    tv[5] = '{100, -100, 60, -61};
    tv[6] = '{1, -2, 0, -2};
    tv[7] = '{0, 0, 0, 0};
`endif
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_cvx", int'(bus.C_Vx), 0);
    check("rst_cvy", int'(bus.C_Vy), 0);
    rst_n = 1;
    @(negedge clk);

    foreach (tv[i]) begin
      send(tv[i].x, tv[i].y, lat);
      check($sformatf("v%0d_latency", i), lat, 9);
      check($sformatf("v%0d_cvx", i), int'(bus.C_Vx), tv[i].ex);
      check($sformatf("v%0d_cvy", i), int'(bus.C_Vy), tv[i].ey);
      drain();
      check($sformatf("v%0d_idle", i), int'(bus.in_ready), 1);
    end

    // Back-pressure: result held, new input ignored while DONE waits.
    send(256, 0, lat);
    bus.Vx = 11'(-256);
    bus.Vy = 11'(1023);
    bus.in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_out_valid", int'(bus.out_valid), 1);
      check("bp_in_ready", int'(bus.in_ready), 0);
      check("bp_cvx", int'(bus.C_Vx), 155);
      check("bp_cvy", int'(bus.C_Vy), 0);
    end
    // out_ready and in_valid together: only the output completes this edge.
    bus.out_ready = 1;
    @(posedge clk);
    #1 bus.out_ready = 0;
    @(negedge clk);
    check("ov_out_valid", int'(bus.out_valid), 0);
    check("ov_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    lat = 1;
    #1 bus.in_valid = 0;
    @(negedge clk);
    check("ov_accepted", int'(bus.in_ready), 0);
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("ov_latency", lat, 9);
    check("ov_cvx", int'(bus.C_Vx), -155);
    check("ov_cvy", int'(bus.C_Vy), 619);
    drain();
    repeat (3) begin
      @(negedge clk);
      check("ov_no_dup", int'(bus.in_ready), 1);
    end

    // Reset during MUL cycle 4 discards the computation.
    wait_ready();
    bus.Vx = 11'(1023);
    bus.Vy = 11'(1023);
    bus.in_valid = 1;
    @(posedge clk);
    #1 bus.in_valid = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    check("mr_in_ready", int'(bus.in_ready), 1);
    check("mr_out_valid", int'(bus.out_valid), 0);
    check("mr_cvx", int'(bus.C_Vx), 0);
    check("mr_cvy", int'(bus.C_Vy), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (12) begin
      @(negedge clk);
      check("mr_no_valid", int'(bus.out_valid), 0);
    end
    send(-1023, 1, lat);
    check("mr_latency", lat, 9);
    check("mr_cvx_after", int'(bus.C_Vx), tv[2].ex);
    check("mr_cvy_after", int'(bus.C_Vy), tv[2].ey);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
